// File: rtl/icache_axi_refill.sv
// rtl/icache_axi_refill.sv - ICache line-refill responder issuing one 8-beat AXI4 read burst per miss
//
// Purpose:
//   Accepts a miss request from the instruction cache, issues a single
//   8-beat 32-bit AXI4 read burst, packs the beats into a 256-bit line and
//   returns it with a one-cycle mem_inst_rvalid_o pulse. Only one refill is
//   ever outstanding.
//
// Optional feature (macro ICACHE_REFILL_CRITICAL_WORD_EN):
//   When defined the burst is WRAP and starts at the requested word, and beat
//   k lands in word slot (addr[4:2]+k) mod 8. When undefined the burst is INCR
//   from the line base and beat k lands in slot k. Line layout is identical.
//
// Ports:
//   clk                clock, rising edge
//   rst                asynchronous active-low reset
//   mem_inst_ren_i     refill request (sampled only while idle)
//   mem_inst_araddr_i  physical miss address
//   mem_inst_rvalid_o  one-cycle line-ready pulse
//   mem_inst_rdata_o   refilled line, word i at [32i+31:32i]
//   bus_err_o          pulses with mem_inst_rvalid_o on bad rresp or bad rlast
//   arid/araddr/arlen/arsize/arburst/arvalid/arready   AXI read address channel
//   rid/rdata/rresp/rlast/rvalid/rready                AXI read data channel

module icache_axi_refill #(
  parameter int              ID_W       = 4,
  parameter logic [ID_W-1:0] AXI_ID     = '0,
  parameter int              LINE_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_inst_ren_i,
  input  logic [31:0]             mem_inst_araddr_i,
  output logic                    mem_inst_rvalid_o,
  output logic [LINE_WORDS*32-1:0] mem_inst_rdata_o,
  output logic                    bus_err_o,
  output logic [ID_W-1:0]         arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_W-1:0]         rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int LINE_W = LINE_WORDS * 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                rvalid_o_q, rvalid_o_d;
  logic                bus_err_q, bus_err_d;
`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
  logic [2:0]          woff_q, woff_d;
`endif

  // Beat bookkeeping shared by next-state and output logic.
  logic                beat_fire;
  logic                last_slot;
  logic                beat_end;
  logic                beat_err;
  logic [2:0]          slot;

  // rid is meaningless with a single outstanding burst; low address bits only
  // matter under the critical-word feature.
  logic                unused_bits;
  assign unused_bits = ^{rid, mem_inst_araddr_i[4:0]};

  assign beat_fire = rready_q && rvalid;
  assign last_slot = (cnt_q == 3'd7);
  assign beat_end  = beat_fire && (rlast || last_slot);
  // rlast must coincide exactly with the 8th beat; either mismatch is an error.
  assign beat_err  = (rresp != 2'b00) || (rlast != last_slot);

`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
  assign slot = cnt_q + woff_q;
`else
  assign slot = cnt_q;
`endif

  // State register and all datapath/output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      line_q     <= '0;
      rvalid_o_q <= 1'b0;
      bus_err_q  <= 1'b0;
`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
      woff_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      line_q     <= line_d;
      rvalid_o_q <= rvalid_o_d;
      bus_err_q  <= bus_err_d;
`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
      woff_q     <= woff_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_inst_ren_i) state_d = S_AR;
      S_AR:    if (arready)        state_d = S_R;
      S_R:     if (beat_end)       state_d = S_DONE;
      S_DONE:                      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are set one cycle ahead so that
  // every port is driven straight from a flop.
  always_comb begin
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    line_d     = line_q;
    rvalid_o_d = 1'b0;
    bus_err_d  = 1'b0;
`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
    woff_d     = woff_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_inst_ren_i) begin
`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
          araddr_d = {mem_inst_araddr_i[31:2], 2'b00};
          woff_d   = mem_inst_araddr_i[4:2];
`else
          araddr_d = {mem_inst_araddr_i[31:5], 5'b0};
`endif
          cnt_d     = '0;
          err_d     = 1'b0;
          arvalid_d = 1'b1;
        end
      end
      S_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_R: begin
        if (beat_fire) begin
          line_d[{slot, 5'b0} +: 32] = rdata;
          cnt_d = cnt_q + 3'd1;
          err_d = err_q || beat_err;
          if (beat_end) begin
            rready_d   = 1'b0;
            rvalid_o_d = 1'b1;
            bus_err_d  = err_q || beat_err;
          end
        end
      end
      default: ;
    endcase
  end

  assign mem_inst_rvalid_o = rvalid_o_q;
  assign mem_inst_rdata_o  = line_q;
  assign bus_err_o         = bus_err_q;
  assign arid              = AXI_ID;
  assign araddr            = araddr_q;
  assign arlen             = 8'd7;
  assign arsize            = 3'b010;
`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
  assign arburst           = 2'b10;
`else
  assign arburst           = 2'b01;
`endif
  assign arvalid           = arvalid_q;
  assign rready            = rready_q;

endmodule

// File: tb/tb_icache_axi_refill.sv
// tb/tb_icache_axi_refill.sv - directed self-checking bench for icache_axi_refill

module tb_icache_axi_refill;

  logic         clk;
  logic         rst_n;
  logic         ren;
  logic [31:0]  addr;
  logic         rvalid_o;
  logic [255:0] line;
  logic         bus_err;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;

  icache_axi_refill dut (
    .clk               (clk),
    .rst               (rst_n),
    .mem_inst_ren_i    (ren),
    .mem_inst_araddr_i (addr),
    .mem_inst_rvalid_o (rvalid_o),
    .mem_inst_rdata_o  (line),
    .bus_err_o         (bus_err),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rvalid_o === 1'b1) pulses++;

  function automatic logic [31:0] exp_araddr(input logic [31:0] a);
`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
    return {a[31:2], 2'b00};
`else
    return {a[31:5], 5'b0};
`endif
  endfunction

  function automatic int exp_slot(input logic [31:0] a, input int k);
`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
    return (int'(a[4:2]) + k) % 8;
`else
    return k;
`endif
  endfunction

`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
  localparam logic [1:0] EXP_BURST = 2'b10;
`else
  localparam logic [1:0] EXP_BURST = 2'b01;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents nbeats beats base+k; err_beat gets SLVERR, last_beat carries rlast.
  task automatic drive_beats(input logic [31:0] base, input int nbeats,
                             input int err_beat, input int last_beat, input bit gaps);
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        rvalid = 1'b0;
        tick();
      end
      rvalid = 1'b1;
      rdata  = base + k;
      rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      rlast  = (k == last_beat);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  // Issues a request with arready high; returns in the first R cycle.
  task automatic start_req(input logic [31:0] a);
    ren     = 1'b1;
    addr    = a;
    arready = 1'b1;
    tick();
    ren = 1'b0;
    tick();
    arready = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({rvalid_o, bus_err, arvalid, rready} !== 4'b0 || araddr !== 32'h0 || line !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rvalid_o=%b bus_err=%b arvalid=%b rready=%b araddr=%h, required all zero",
               rvalid_o, bus_err, arvalid, rready, araddr);
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (arvalid !== 1'b0 || rvalid_o !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: %0d cycles with arvalid/rvalid_o set, required 0", bad);
    end
  endtask

  task automatic test_basic();
    logic [31:0] a;
    a = 32'h1FC0_0124;
    ren = 1'b1; addr = a; arready = 1'b1;
    tick();
    ren = 1'b0;
    n_cmp++;
    if (arvalid !== 1'b1 || araddr !== exp_araddr(a)) begin
      n_fail++;
      $display("FAIL basic_ar: arvalid=%b araddr=%h, required 1 %h", arvalid, araddr, exp_araddr(a));
    end
    n_cmp++;
    if (arlen !== 8'd7 || arsize !== 3'b010 || arburst !== EXP_BURST || arid !== 4'h0) begin
      n_fail++;
      $display("FAIL basic_arconst: arlen=%h arsize=%b arburst=%b arid=%h, required 07 010 %b 0",
               arlen, arsize, arburst, arid, EXP_BURST);
    end
    tick();
    arready = 1'b0;
    n_cmp++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_rready: rready=%b arvalid=%b, required 1 0", rready, arvalid);
    end
    drive_beats(32'hA0, 8, -1, 7, 1'b0);
    n_cmp++;
    if (rvalid_o !== 1'b1 || bus_err !== 1'b0 || rready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_cycle10: rvalid_o=%b bus_err=%b rready=%b, required 1 0 0", rvalid_o, bus_err, rready);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (line[32*exp_slot(a, k) +: 32] !== 32'hA0 + k) begin
        n_fail++;
        $display("FAIL basic_word%0d: got %h, required %h", exp_slot(a, k),
                 line[32*exp_slot(a, k) +: 32], 32'hA0 + k);
      end
    end
    tick();
    n_cmp++;
    if (rvalid_o !== 1'b0 || line[31:0] !== 32'hA0 + exp_slot(a, 0) * 0 + ((8 - exp_slot(a, 0)) % 8)) begin
      n_fail++;
      $display("FAIL basic_pulse_end: rvalid_o=%b word0=%h, required 0 %h", rvalid_o, line[31:0],
               32'hA0 + ((8 - exp_slot(a, 0)) % 8));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, a0;
    int bad, p0;
    a  = 32'h0000_3FE8;
    p0 = pulses;
    ren = 1'b1; addr = a; arready = 1'b0;
    tick();
    a0  = araddr;
    bad = 0;
    repeat (5) begin
      tick();
      if (arvalid !== 1'b1 || araddr !== a0) bad++;
    end
    n_cmp++;
    if (bad != 0 || a0 !== exp_araddr(a)) begin
      n_fail++;
      $display("FAIL bp_ar_hold: %0d unstable cycles, araddr=%h, required 0 %h", bad, a0, exp_araddr(a));
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    drive_beats(32'hD0, 8, -1, 7, 1'b1);
    n_cmp++;
    if (rvalid_o !== 1'b1 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: rvalid_o=%b bus_err=%b, required 1 0", rvalid_o, bus_err);
    end
    bad = 0;
    for (int k = 0; k < 8; k++) if (line[32*exp_slot(a, k) +: 32] !== 32'hD0 + k) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_line: %0d wrong words, required 0", bad);
    end
    tick();
    n_cmp++;
    if (arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ren_in_done: arvalid=%b, required 0", arvalid);
    end
    ren = 1'b0;
    tick();
    n_cmp++;
    if (arvalid !== 1'b0 || pulses - p0 != 1) begin
      n_fail++;
      $display("FAIL bp_single_pulse: arvalid=%b pulses=%0d, required 0 1", arvalid, pulses - p0);
    end
  endtask

  task automatic test_errors();
    start_req(32'h0000_0100);
    drive_beats(32'hC0, 8, 2, 7, 1'b0);
    n_cmp++;
    if (rvalid_o !== 1'b1 || bus_err !== 1'b1 || line[95:64] !== 32'hC2) begin
      n_fail++;
      $display("FAIL slverr: rvalid_o=%b bus_err=%b word2=%h, required 1 1 000000c2", rvalid_o, bus_err, line[95:64]);
    end
    tick();
    n_cmp++;
    if (bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL slverr_pulse: bus_err=%b, required 0", bus_err);
    end
    start_req(32'h0000_0200);
    drive_beats(32'hE0, 5, -1, 4, 1'b0);
    n_cmp++;
    if (rvalid_o !== 1'b1 || bus_err !== 1'b1 || rready !== 1'b0) begin
      n_fail++;
      $display("FAIL early_rlast: rvalid_o=%b bus_err=%b rready=%b, required 1 1 0", rvalid_o, bus_err, rready);
    end
    n_cmp++;
    if (line[159:128] !== 32'hE4 || line[191:160] !== 32'hC5) begin
      n_fail++;
      $display("FAIL early_rlast_line: word4=%h word5=%h, required 000000e4 000000c5", line[159:128], line[191:160]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int p0;
    start_req(32'h0000_4040);
    drive_beats(32'hF0, 4, -1, -1, 1'b0);
    p0    = pulses;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({rvalid_o, bus_err, arvalid, rready} !== 4'b0 || araddr !== 32'h0 || line !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: rvalid_o=%b bus_err=%b arvalid=%b rready=%b araddr=%h, required all zero",
               rvalid_o, bus_err, arvalid, rready, araddr);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (pulses != p0 || arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: pulses=%0d arvalid=%b, required %0d 0", pulses, arvalid, p0);
    end
    start_req(32'h0000_4040);
    drive_beats(32'h5A00, 8, -1, 7, 1'b0);
    n_cmp++;
    if (rvalid_o !== 1'b1 || bus_err !== 1'b0 || line[255:224] !== 32'h5A07) begin
      n_fail++;
      $display("FAIL reset_mid_recover: rvalid_o=%b bus_err=%b word7=%h, required 1 0 00005a07",
               rvalid_o, bus_err, line[255:224]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start_req(32'h0000_0080);
    drive_beats(32'h60, 8, -1, 7, 1'b0);
    ren  = 1'b1;
    addr = 32'h0000_00A0;
    tick();
    n_cmp++;
    if (arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: arvalid=%b, required 0", arvalid);
    end
    arready = 1'b1;
    tick();
    ren = 1'b0;
    n_cmp++;
    if (arvalid !== 1'b1 || araddr !== exp_araddr(32'h0000_00A0)) begin
      n_fail++;
      $display("FAIL b2b_second_ar: arvalid=%b araddr=%h, required 1 %h", arvalid, araddr,
               exp_araddr(32'h0000_00A0));
    end
    tick();
    arready = 1'b0;
    drive_beats(32'h70, 8, -1, 7, 1'b0);
    n_cmp++;
    if (rvalid_o !== 1'b1 || line[31:0] !== 32'h70) begin
      n_fail++;
      $display("FAIL b2b_second_line: rvalid_o=%b word0=%h, required 1 00000070", rvalid_o, line[31:0]);
    end
    tick();
  endtask

`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
  task automatic test_critical_word();
    ren = 1'b1; addr = 32'h0000_0114; arready = 1'b1;
    tick();
    ren = 1'b0;
    n_cmp++;
    if (araddr !== 32'h0000_0114 || arburst !== 2'b10) begin
      n_fail++;
      $display("FAIL cw_ar: araddr=%h arburst=%b, required 00000114 10", araddr, arburst);
    end
    tick();
    arready = 1'b0;
    drive_beats(32'hB0, 8, -1, 7, 1'b0);
    n_cmp++;
    if (line[191:160] !== 32'hB0 || line[223:192] !== 32'hB1 || line[159:128] !== 32'hB7 || line[31:0] !== 32'hB3) begin
      n_fail++;
      $display("FAIL cw_line: w5=%h w6=%h w4=%h w0=%h, required b0 b1 b7 b3",
               line[191:160], line[223:192], line[159:128], line[31:0]);
    end
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0; ren = 1'b0; addr = '0; arready = 1'b0;
    rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_back_to_back();
`ifdef ICACHE_REFILL_CRITICAL_WORD_EN
    test_critical_word();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
